// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared constants for the unified-memory port arbiter: FSM state
//               encoding, requester port indices, default access latency and
//               bus/counter widths.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    // FSM state encoding
    localparam int       c_ST_W      = 2;
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCESS = 2'd1;
    localparam logic [1:0] c_ST_DONE   = 2'd2;

    // Requester port indices (also the encoding of the owner output)
    localparam logic c_PORT_CPU = 1'b0;
    localparam logic c_PORT_LD  = 1'b1;

    // Default memory access duration in cycles (legal 1..15)
    localparam int c_MEM_LAT_DEFAULT = 1;

    // Widths
    localparam int c_ADDR_W = 32;
    localparam int c_DATA_W = 32;
    localparam int c_CNT_W  = 4;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Bundle of the two requester ports (CPU, loader) and the
//               unified-memory port served by mem_port_arbiter.
// Ports       : none; modports:
//               slave  - arbiter view (takes requests, drives memory strobes)
//               master - environment view (drives requests, receives acks)
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    // CPU port
    logic                cpu_req;
    logic                cpu_we;
    logic [c_ADDR_W-1:0] cpu_addr;
    logic [c_DATA_W-1:0] cpu_wdata;
    logic                cpu_ack;
    logic [c_DATA_W-1:0] cpu_rdata;
    logic                cpu_stall;

    // Loader / DMA port
    logic                ld_req;
    logic                ld_we;
    logic [c_ADDR_W-1:0] ld_addr;
    logic [c_DATA_W-1:0] ld_wdata;
    logic                ld_ack;
    logic [c_DATA_W-1:0] ld_rdata;

    // Unified memory port
    logic                mem_read;
    logic                mem_write;
    logic [c_ADDR_W-1:0] mem_addr;
    logic [c_DATA_W-1:0] mem_wdata;
    logic [c_DATA_W-1:0] mem_rdata;

    // Status
    logic                busy;
    logic                owner;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata, cpu_stall,
        input  ld_req, ld_we, ld_addr, ld_wdata,
        output ld_ack, ld_rdata,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy, owner
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata, cpu_stall,
        output ld_req, ld_we, ld_addr, ld_wdata,
        input  ld_ack, ld_rdata,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy, owner
    );

endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter, purely combinational. A single
//               requester always wins; on a tie the port that was not the
//               last grantee wins.
// Ports       : i_req[1:0]  request per port (index = port number)
//               i_lastGnt   last grantee (0 = CPU, 1 = loader)
//               o_grant[1:0] one-hot grant, zero when nobody requests
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import mem_port_arbiter_pkg::*;
(
    input  wire [1:0] i_req,
    input  wire       i_lastGnt,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = 2'b00;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            // Tie: hand the memory to whoever did not have it last time
            2'b11:   o_grant = (i_lastGnt == c_PORT_LD) ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one unified memory between a multicycle CPU and a
//               loader/DMA port. Each access latches the winner's request,
//               strobes memory for MEM_LAT cycles, then pulses the winner's
//               ack for one cycle. Round-robin arbitration on ties.
// Ports       : clk  - clock, rising edge
//               rst  - synchronous active-high reset
//               bus  - mem_port_arbiter_if.slave: CPU port (req/we/addr/wdata,
//                      ack/rdata/stall), loader port (req/we/addr/wdata,
//                      ack/rdata), memory port (read/write/addr/wdata,
//                      rdata), status (busy, owner)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_LAT = c_MEM_LAT_DEFAULT   // legal 1..15
) (
    input  wire clk,
    input  wire rst,
    mem_port_arbiter_if.slave bus
);

    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(MEM_LAT - 1);

    logic [c_ST_W-1:0]   r_state;
    logic [c_ST_W-1:0]   w_stateNext;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_owner;      // current/last grantee
    logic                r_we;
    logic [c_ADDR_W-1:0] r_addr;
    logic [c_DATA_W-1:0] r_wdata;
    logic [c_DATA_W-1:0] r_cpuRdata;
    logic [c_DATA_W-1:0] r_ldRdata;
    logic [1:0]          w_req;
    logic [1:0]          w_grant;

    assign w_req[c_PORT_CPU] = bus.cpu_req;
    assign w_req[c_PORT_LD]  = bus.ld_req;

    rr_arb2 u_arb (
        .i_req     (w_req),
        .i_lastGnt (r_owner),
        .o_grant   (w_grant)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            c_ST_IDLE:   if (|w_req) w_stateNext = c_ST_ACCESS;
            c_ST_ACCESS: if (r_cnt == '0) w_stateNext = c_ST_DONE;
            c_ST_DONE:   w_stateNext = c_ST_IDLE;
            default:     w_stateNext = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch, access counter and read-data capture. Everything the
    // access needs is copied here on the IDLE->ACCESS edge so requesters
    // may change or drop their inputs while the access is in flight.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_owner    <= c_PORT_LD;   // CPU wins the first tie
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_cpuRdata <= '0;
            r_ldRdata  <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (|w_req) begin
                        r_owner <= w_grant[c_PORT_LD];
                        r_cnt   <= c_CNT_LOAD;
                        if (w_grant[c_PORT_CPU]) begin
                            r_we    <= bus.cpu_we;
                            r_addr  <= bus.cpu_addr;
                            r_wdata <= bus.cpu_wdata;
                        end else begin
                            r_we    <= bus.ld_we;
                            r_addr  <= bus.ld_addr;
                            r_wdata <= bus.ld_wdata;
                        end
                    end
                end
                c_ST_ACCESS: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (!r_we) begin
                        // Last strobe cycle: memory data is valid now
                        if (r_owner == c_PORT_LD) begin
                            r_ldRdata <= bus.mem_rdata;
                        end else begin
                            r_cpuRdata <= bus.mem_rdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.cpu_ack   = 1'b0;
        bus.ld_ack    = 1'b0;
        case (r_state)
            c_ST_ACCESS: begin
                bus.mem_read  = ~r_we;
                bus.mem_write =  r_we;
            end
            c_ST_DONE: begin
                bus.cpu_ack = (r_owner == c_PORT_CPU);
                bus.ld_ack  = (r_owner == c_PORT_LD);
            end
            default: ;
        endcase
    end

    assign bus.cpu_stall = bus.cpu_req & ~bus.cpu_ack;
    assign bus.busy      = (r_state != c_ST_IDLE);
    assign bus.owner     = r_owner;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.cpu_rdata = r_cpuRdata;
    assign bus.ld_rdata  = r_ldRdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. Directed scenarios
//               on a MEM_LAT=1 and a MEM_LAT=3 instance, then randomized
//               traffic on the MEM_LAT=3 instance checked against a
//               timeline model (grant edge, strobe window, ack cycle).
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int L3 = 3;

    logic clk;
    logic rst;
    int   nChecks;
    int   nFail;

    mem_port_arbiter_if bus1 ();
    mem_port_arbiter_if bus3 ();

    mem_port_arbiter #(.MEM_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    mem_port_arbiter #(.MEM_LAT(L3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Advance past the next rising edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus1.cpu_req = 1'b0; bus1.cpu_we = 1'b0; bus1.cpu_addr = '0; bus1.cpu_wdata = '0;
        bus1.ld_req  = 1'b0; bus1.ld_we  = 1'b0; bus1.ld_addr  = '0; bus1.ld_wdata  = '0;
        bus1.mem_rdata = '0;
        bus3.cpu_req = 1'b0; bus3.cpu_we = 1'b0; bus3.cpu_addr = '0; bus3.cpu_wdata = '0;
        bus3.ld_req  = 1'b0; bus3.ld_we  = 1'b0; bus3.ld_addr  = '0; bus3.ld_wdata  = '0;
        bus3.mem_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [6:0] act;
        do_reset();
        act = {bus3.mem_read, bus3.mem_write, bus3.cpu_ack, bus3.ld_ack, bus3.busy, bus3.owner, bus3.cpu_stall};
        nChecks++;
        if (act !== 7'b0000010) begin
            nFail++; $display("FAIL reset_ctl: got %b expected %b", act, 7'b0000010);
        end
        nChecks++;
        if ({bus3.cpu_rdata, bus3.ld_rdata} !== 64'h0) begin
            nFail++; $display("FAIL reset_rdata: got %h/%h expected 0/0", bus3.cpu_rdata, bus3.ld_rdata);
        end
        nChecks++;
        if ({bus3.mem_addr, bus3.mem_wdata} !== 64'h0) begin
            nFail++; $display("FAIL reset_mem: got %h/%h expected 0/0", bus3.mem_addr, bus3.mem_wdata);
        end
        nChecks++;
        if (bus1.owner !== 1'b1 || bus1.busy !== 1'b0) begin
            nFail++; $display("FAIL reset_lat1: got owner=%b busy=%b expected owner=1 busy=0", bus1.owner, bus1.busy);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_read_lat1();
        do_reset();
        bus1.cpu_req = 1'b1; bus1.cpu_we = 1'b0; bus1.cpu_addr = 32'h4;
        bus1.mem_rdata = 32'h8C220000;
        tick();
        nChecks++;
        if ({bus1.mem_read, bus1.mem_write, bus1.cpu_ack, bus1.cpu_stall} !== 4'b1001 || bus1.mem_addr !== 32'h4) begin
            nFail++; $display("FAIL lat1_strobe: got rd/wr/ack/stall=%b addr=%h expected 1001 addr=00000004",
                              {bus1.mem_read, bus1.mem_write, bus1.cpu_ack, bus1.cpu_stall}, bus1.mem_addr);
        end
        tick();
        nChecks++;
        if ({bus1.mem_read, bus1.cpu_ack, bus1.cpu_stall, bus1.ld_ack} !== 4'b0100 || bus1.cpu_rdata !== 32'h8C220000) begin
            nFail++; $display("FAIL lat1_ack: got rd/ack/stall/ldack=%b rdata=%h expected 0100 rdata=8c220000",
                              {bus1.mem_read, bus1.cpu_ack, bus1.cpu_stall, bus1.ld_ack}, bus1.cpu_rdata);
        end
        bus1.cpu_req = 1'b0; bus1.mem_rdata = 32'h0;
        tick();
        nChecks++;
        if (bus1.cpu_ack !== 1'b0 || bus1.busy !== 1'b0 || bus1.cpu_rdata !== 32'h8C220000) begin
            nFail++; $display("FAIL lat1_hold: got ack=%b busy=%b rdata=%h expected 0 0 8c220000",
                              bus1.cpu_ack, bus1.busy, bus1.cpu_rdata);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_write_lat3();
        do_reset();
        bus3.ld_req = 1'b1; bus3.ld_we = 1'b1; bus3.ld_addr = 32'h10; bus3.ld_wdata = 32'hDEADBEEF;
        bus3.mem_rdata = 32'hFFFF0000;
        for (int i = 0; i < L3; i++) begin
            tick();
            nChecks++;
            if ({bus3.mem_write, bus3.mem_read, bus3.ld_ack} !== 3'b100 || bus3.mem_wdata !== 32'hDEADBEEF
                || bus3.mem_addr !== 32'h10) begin
                nFail++; $display("FAIL wr3_strobe%0d: got wr/rd/ack=%b addr=%h wdata=%h expected 100 00000010 deadbeef",
                                  i, {bus3.mem_write, bus3.mem_read, bus3.ld_ack}, bus3.mem_addr, bus3.mem_wdata);
            end
        end
        tick();
        nChecks++;
        if ({bus3.mem_write, bus3.ld_ack, bus3.cpu_ack, bus3.owner} !== 4'b0101 || bus3.ld_rdata !== 32'h0) begin
            nFail++; $display("FAIL wr3_ack: got wr/ldack/cpuack/owner=%b ld_rdata=%h expected 0101 00000000",
                              {bus3.mem_write, bus3.ld_ack, bus3.cpu_ack, bus3.owner}, bus3.ld_rdata);
        end
        bus3.ld_req = 1'b0;
        tick();
        nChecks++;
        if (bus3.ld_ack !== 1'b0 || bus3.ld_rdata !== 32'h0) begin
            nFail++; $display("FAIL wr3_after: got ack=%b ld_rdata=%h expected 0 00000000", bus3.ld_ack, bus3.ld_rdata);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_arbitration();
        int win;
        logic [31:0] rd;
        do_reset();
        bus3.cpu_req = 1'b1; bus3.cpu_we = 1'b0; bus3.cpu_addr = 32'h100;
        bus3.ld_req  = 1'b1; bus3.ld_we  = 1'b0; bus3.ld_addr  = 32'h200;
        for (int g = 0; g < 3; g++) begin
            win = g % 2;                      // CPU, loader, CPU
            bus3.mem_rdata = 32'h5A5A0000 + 32'(g);
            tick();
            nChecks++;
            if (bus3.owner !== 1'(win) || bus3.mem_addr !== ((win == 1) ? 32'h200 : 32'h100)) begin
                nFail++; $display("FAIL arb_grant%0d: got owner=%b addr=%h expected owner=%0d", g, bus3.owner, bus3.mem_addr, win);
            end
            tick();
            tick();
            tick();
            rd = (win == 1) ? bus3.ld_rdata : bus3.cpu_rdata;
            nChecks++;
            if ({bus3.cpu_ack, bus3.ld_ack} !== {1'(win == 0), 1'(win == 1)} || rd !== 32'h5A5A0000 + 32'(g)) begin
                nFail++; $display("FAIL arb_ack%0d: got cpu/ld ack=%b%b rdata=%h expected winner %0d rdata=%h",
                                  g, bus3.cpu_ack, bus3.ld_ack, rd, win, 32'h5A5A0000 + 32'(g));
            end
            tick();
        end
        bus3.cpu_req = 1'b0; bus3.ld_req = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_addr_hold();
        do_reset();
        bus3.cpu_req = 1'b1; bus3.cpu_we = 1'b0; bus3.cpu_addr = 32'h20;
        tick();
        bus3.cpu_addr = 32'h40;
        for (int i = 0; i < L3 + 1; i++) begin
            nChecks++;
            if (bus3.mem_addr !== 32'h20) begin
                nFail++; $display("FAIL addr_hold%0d: got %h expected 00000020", i, bus3.mem_addr);
            end
            if (i < L3) tick();
        end
        nChecks++;
        if (bus3.cpu_ack !== 1'b1) begin
            nFail++; $display("FAIL addr_hold_ack: got %b expected 1", bus3.cpu_ack);
        end
        bus3.cpu_req = 1'b0;
        tick();
        nChecks++;
        if (bus3.mem_addr !== 32'h20 || bus3.busy !== 1'b0) begin
            nFail++; $display("FAIL addr_hold_idle: got addr=%h busy=%b expected 00000020 0", bus3.mem_addr, bus3.busy);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid_access();
        logic [6:0] act;
        do_reset();
        bus3.cpu_req = 1'b1; bus3.cpu_we = 1'b0; bus3.cpu_addr = 32'h30; bus3.mem_rdata = 32'h12345678;
        tick();
        nChecks++;
        if ({bus3.mem_read, bus3.busy, bus3.owner} !== 3'b110) begin
            nFail++; $display("FAIL rstmid_start: got rd/busy/owner=%b expected 110", {bus3.mem_read, bus3.busy, bus3.owner});
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        act = {bus3.mem_read, bus3.mem_write, bus3.cpu_ack, bus3.ld_ack, bus3.busy, bus3.owner, bus3.cpu_stall};
        nChecks++;
        if (act !== 7'b0000011 || bus3.mem_addr !== 32'h0 || bus3.cpu_rdata !== 32'h0) begin
            nFail++; $display("FAIL rstmid_abort: got ctl=%b addr=%h rdata=%h expected 0000011 0 0", act, bus3.mem_addr, bus3.cpu_rdata);
        end
        for (int i = 0; i < L3; i++) begin
            tick();
            nChecks++;
            if ({bus3.cpu_ack, bus3.mem_read} !== 2'b01 || bus3.mem_addr !== 32'h30) begin
                nFail++; $display("FAIL rstmid_redo%0d: got ack/rd=%b addr=%h expected 01 00000030",
                                  i, {bus3.cpu_ack, bus3.mem_read}, bus3.mem_addr);
            end
        end
        tick();
        nChecks++;
        if (bus3.cpu_ack !== 1'b1 || bus3.cpu_rdata !== 32'h12345678) begin
            nFail++; $display("FAIL rstmid_ack: got ack=%b rdata=%h expected 1 12345678", bus3.cpu_ack, bus3.cpu_rdata);
        end
        bus3.cpu_req = 1'b0;
        tick();
    endtask

    // ------------------------------------------------------------------
    // Random traffic. The model is a timeline: an access granted at edge s
    // strobes for intervals s..s+L-1, acks in interval s+L and the arbiter
    // can grant again at edge s+L+2.
    // ------------------------------------------------------------------
    task automatic test_random();
        int          mStart, freeAt, mWin, lastGnt;
        logic        mWe;
        logic [31:0] mAddr, mWdata;
        logic [31:0] rdExp [2];
        logic        inAcc, ackC, ackL, busyE, flight;
        logic [6:0]  expCtl, actCtl;
        logic [1:0]  req;

        do_reset();
        lastGnt = 1; mStart = -1000; freeAt = 0; mWin = 0; mWe = 1'b0;
        mAddr = '0; mWdata = '0; rdExp[0] = '0; rdExp[1] = '0;

        for (int e = 0; e < 400; e++) begin
            // Model the edge e using the inputs currently held
            if (e == mStart + L3 && !mWe) rdExp[mWin] = bus3.mem_rdata;
            if (e >= freeAt && (bus3.cpu_req || bus3.ld_req)) begin
                if (bus3.cpu_req && bus3.ld_req) mWin = 1 - lastGnt;
                else mWin = bus3.ld_req ? 1 : 0;
                lastGnt = mWin;
                mStart  = e;
                freeAt  = e + L3 + 2;
                mWe     = (mWin == 1) ? bus3.ld_we    : bus3.cpu_we;
                mAddr   = (mWin == 1) ? bus3.ld_addr  : bus3.cpu_addr;
                mWdata  = (mWin == 1) ? bus3.ld_wdata : bus3.cpu_wdata;
            end

            tick();

            inAcc  = (e >= mStart) && (e < mStart + L3);
            ackC   = (e == mStart + L3) && (mWin == 0);
            ackL   = (e == mStart + L3) && (mWin == 1);
            busyE  = (e >= mStart) && (e <= mStart + L3);
            expCtl = {inAcc & ~mWe, inAcc & mWe, ackC, ackL, busyE, 1'(lastGnt), bus3.cpu_req & ~ackC};
            actCtl = {bus3.mem_read, bus3.mem_write, bus3.cpu_ack, bus3.ld_ack, bus3.busy, bus3.owner, bus3.cpu_stall};

            nChecks++;
            if (actCtl !== expCtl) begin
                nFail++; $display("FAIL rnd_ctl@%0d: got rd/wr/cack/lack/busy/own/stall=%b expected %b", e, actCtl, expCtl);
            end
            nChecks++;
            if (bus3.mem_addr !== mAddr || bus3.mem_wdata !== mWdata) begin
                nFail++; $display("FAIL rnd_mem@%0d: got addr=%h wdata=%h expected %h %h",
                                  e, bus3.mem_addr, bus3.mem_wdata, mAddr, mWdata);
            end
            nChecks++;
            if (bus3.cpu_rdata !== rdExp[0] || bus3.ld_rdata !== rdExp[1]) begin
                nFail++; $display("FAIL rnd_rdata@%0d: got cpu=%h ld=%h expected %h %h",
                                  e, bus3.cpu_rdata, bus3.ld_rdata, rdExp[0], rdExp[1]);
            end

            // Requester behaviour: hold until ack, occasionally drop mid-access
            req = {bus3.ld_req, bus3.cpu_req};
            for (int p = 0; p < 2; p++) begin
                flight = busyE && (mWin == p);
                if (!req[p]) req[p] = 1'($urandom_range(0, 1));
                else if ((p == 0 && ackC) || (p == 1 && ackL)) req[p] = 1'($urandom_range(0, 1));
                else if (flight) req[p] = ($urandom_range(0, 7) != 0);
            end
            bus3.cpu_req   = req[0];
            bus3.ld_req    = req[1];
            bus3.cpu_we    = 1'($urandom_range(0, 1));
            bus3.ld_we     = 1'($urandom_range(0, 1));
            bus3.cpu_addr  = $urandom;
            bus3.ld_addr   = $urandom;
            bus3.cpu_wdata = $urandom;
            bus3.ld_wdata  = $urandom;
            bus3.mem_rdata = $urandom;
        end
        idle_inputs();
        tick();
    endtask

    // ------------------------------------------------------------------
    initial begin
        nChecks = 0;
        nFail   = 0;
        rst     = 1'b1;
        idle_inputs();
        test_reset();
        test_read_lat1();
        test_write_lat3();
        test_arbitration();
        test_addr_hold();
        test_reset_mid_access();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
`default_nettype wire
